// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
// States, port ids and the wait-counter width.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } stateT;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/sram_arb_priority.sv
// Grant selection between the video reader and the general port.
// A wins by default; B is forced after pStarveMax overtakes.
module sram_arb_priority
  import sram_arb_pkg::*;
#(
  parameter int pStarveMax = 4
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iAReq,
  input  logic iBReq,
  input  logic iIdle,
  output logic oGntVd,
  output logic oGntId
);

  logic [WAIT_W-1:0] starveCnt;
  logic              starved;

  assign starved = (starveCnt == WAIT_W'(pStarveMax));
  assign oGntVd  = iIdle & (iAReq | iBReq);
  assign oGntId  = (iBReq & (~iAReq | starved)) ? PORT_B : PORT_A;

  // count A grants that overtook a waiting B; only moves in IDLE
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      starveCnt <= '0;
    end else if (iIdle) begin
      if (!iBReq || oGntId == PORT_B) begin
        starveCnt <= '0;
      end else if (!starved) begin
        starveCnt <= starveCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Async SRAM sequencer shared by the video reader and general port.
// Owns strobe timing, DQ tri-state and the read data registers.
module sram_arbiter_ctrl
  import sram_arb_pkg::*;
#(
  parameter int pAdrsWidth = 19,
  parameter int pDqWidth   = 8,
  parameter int pRdWait    = 2,
  parameter int pWrWait    = 2,
  parameter int pStarveMax = 4
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iAReq,
  input  logic [pAdrsWidth-1:0] iAAdrs,
  output logic                  oAGnt,
  output logic                  oARdVd,
  output logic [pDqWidth-1:0]   oARdData,
  input  logic                  iBReq,
  input  logic                  iBWe,
  input  logic [pAdrsWidth-1:0] iBAdrs,
  input  logic [pDqWidth-1:0]   iBWrData,
  output logic                  oBGnt,
  output logic                  oBRdVd,
  output logic [pDqWidth-1:0]   oBRdData,
  output logic [pAdrsWidth-1:0] oMemAdrs,
  inout  wire  [pDqWidth-1:0]   ioMemDq,
  output logic                  oMemCE,
  output logic                  oMemOE,
  output logic                  oMemWE,
  output logic                  oBusy
);

  stateT                 state;
  logic [WAIT_W-1:0]     waitCnt;
  logic                  curPort;
  logic [pDqWidth-1:0]   wrData;
  logic                  dqOe;
  logic                  idle;
  logic                  gntVd;
  logic                  gntId;
  logic                  selWe;
  logic [pAdrsWidth-1:0] selAdrs;

  assign idle    = (state == IDLE);
  assign oBusy   = ~idle;
  assign selWe   = (gntId == PORT_B) & iBWe;
  assign selAdrs = (gntId == PORT_B) ? iBAdrs : iAAdrs;
  assign ioMemDq = dqOe ? wrData : {pDqWidth{1'bz}};

  sram_arb_priority #(
    .pStarveMax(pStarveMax)
  ) uPrio (
    .iClk  (iClk),
    .iRst  (iRst),
    .iAReq (iAReq),
    .iBReq (iBReq),
    .iIdle (idle),
    .oGntVd(gntVd),
    .oGntId(gntId)
  );

  // access sequencer: strobes, DQ enable and pulses all registered
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      waitCnt  <= '0;
      curPort  <= PORT_A;
      wrData   <= '0;
      dqOe     <= 1'b0;
      oMemAdrs <= '0;
      oMemCE   <= 1'b1;
      oMemOE   <= 1'b1;
      oMemWE   <= 1'b1;
      oAGnt    <= 1'b0;
      oBGnt    <= 1'b0;
      oARdVd   <= 1'b0;
      oBRdVd   <= 1'b0;
      oARdData <= '0;
      oBRdData <= '0;
    end else begin
      oAGnt  <= 1'b0;
      oBGnt  <= 1'b0;
      oARdVd <= 1'b0;
      oBRdVd <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gntVd) begin
            curPort  <= gntId;
            oMemAdrs <= selAdrs;
            oMemCE   <= 1'b0;
            if (gntId == PORT_A) oAGnt <= 1'b1;
            else oBGnt <= 1'b1;
            if (selWe) begin
              wrData <= iBWrData;
              dqOe   <= 1'b1;
              state  <= WR_SETUP;
            end else begin
              oMemOE  <= 1'b0;
              waitCnt <= WAIT_W'(pRdWait - 1);
              state   <= RD;
            end
          end
        end
        RD: begin
          if (waitCnt == '0) begin
            if (curPort == PORT_A) begin
              oARdData <= ioMemDq;
              oARdVd   <= 1'b1;
            end else begin
              oBRdData <= ioMemDq;
              oBRdVd   <= 1'b1;
            end
            oMemCE <= 1'b1;
            oMemOE <= 1'b1;
            state  <= IDLE;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        WR_SETUP: begin
          oMemWE  <= 1'b0;
          waitCnt <= WAIT_W'(pWrWait - 1);
          state   <= WR_PULSE;
        end
        WR_PULSE: begin
          if (waitCnt == '0) begin
            oMemWE <= 1'b1;
            state  <= WR_HOLD;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        WR_HOLD: begin
          oMemCE <= 1'b1;
          dqOe   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Bench for sram_arbiter_ctrl with a behavioural async SRAM.
// Directed vectors, corner sequences and a randomized model check.
module tb_sram_arbiter_ctrl;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int RD_WAIT = 2;
  localparam int STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          aReq;
  logic [AW-1:0] aAdrs;
  logic          aGnt;
  logic          aRdVd;
  logic [DW-1:0] aRdData;
  logic          bReq;
  logic          bWe;
  logic [AW-1:0] bAdrs;
  logic [DW-1:0] bWrData;
  logic          bGnt;
  logic          bRdVd;
  logic [DW-1:0] bRdData;
  logic [AW-1:0] memAdrs;
  wire  [DW-1:0] memDq;
  logic          memCE;
  logic          memOE;
  logic          memWE;
  logic          busy;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int nChecks = 0;
  int nFails = 0;

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] adrs;
    logic [DW-1:0] wdata;
    logic [DW-1:0] expData;
  } vecT;

  vecT vecs [6];

  always #5 clk = ~clk;

  sram_arbiter_ctrl dut (
    .iClk    (clk),
    .iRst    (rst),
    .iAReq   (aReq),
    .iAAdrs  (aAdrs),
    .oAGnt   (aGnt),
    .oARdVd  (aRdVd),
    .oARdData(aRdData),
    .iBReq   (bReq),
    .iBWe    (bWe),
    .iBAdrs  (bAdrs),
    .iBWrData(bWrData),
    .oBGnt   (bGnt),
    .oBRdVd  (bRdVd),
    .oBRdData(bRdData),
    .oMemAdrs(memAdrs),
    .ioMemDq (memDq),
    .oMemCE  (memCE),
    .oMemOE  (memOE),
    .oMemWE  (memWE),
    .oBusy   (busy)
  );

  function automatic logic [DW-1:0] seedVal(input int j);
    return 8'((j * 37) ^ 8'h5C);
  endfunction

  // SRAM device: drives DQ on read, captures while WE is low
  assign memDq = (!memCE && !memOE) ? mem[memAdrs] : {DW{1'bz}};

  initial begin
    for (int j = 0; j < 16; j++) mem[32'h100 + j] = seedVal(j);
    mem[32'h10]    = 8'h5A;
    mem[32'h7FFFF] = 8'h00;
    forever begin
      @(posedge clk);
      if (!memCE && !memWE) mem[memAdrs] = memDq;
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // strobe invariants on every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      if (!memOE) check("oe excl", {memWE, memCE}, 2'b10);
      if (!memWE) check("we in ce", {memCE, memOE}, 2'b01);
    end
  end

  task automatic idleInputs();
    aReq = 1'b0;
    bReq = 1'b0;
    bWe = 1'b0;
  endtask

  task automatic runVec(input int id, input vecT v);
    int gntAt = -1;
    int vdAt = -1;
    int nGnt = 0;
    int nVd = 0;
    int oeLow = 0;
    int weLow = 0;
    int dqBad = 0;
    logic [DW-1:0] rd = '0;
    @(negedge clk);
    if (v.port) begin
      bReq = 1'b1; bWe = v.we; bAdrs = v.adrs; bWrData = v.wdata;
    end else begin
      aReq = 1'b1; aAdrs = v.adrs;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (v.port ? bGnt : aGnt) begin
        nGnt++;
        if (gntAt < 0) gntAt = c;
        idleInputs();
      end
      if (v.port ? bRdVd : aRdVd) begin
        nVd++;
        vdAt = c;
        rd = v.port ? bRdData : aRdData;
      end
      if (!memOE) oeLow++;
      if (!memWE) begin
        weLow++;
        if (memDq !== v.wdata) dqBad++;
      end
    end
    check($sformatf("vec%0d gnt count", id), nGnt, 1);
    check($sformatf("vec%0d gnt cycle", id), gntAt, 1);
    check($sformatf("vec%0d rdvd count", id), nVd, v.we ? 0 : 1);
    check($sformatf("vec%0d oe low", id), oeLow, v.we ? 0 : 2);
    check($sformatf("vec%0d we low", id), weLow, v.we ? 2 : 0);
    check($sformatf("vec%0d dq during we", id), dqBad, 0);
    if (!v.we) begin
      check($sformatf("vec%0d rdvd cycle", id), vdAt, 1 + RD_WAIT);
      check($sformatf("vec%0d rd data", id), rd, v.expData);
    end
  endtask

  task automatic starveSeq();
    logic q [$];
    logic expSeq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    @(negedge clk);
    aReq = 1'b1; aAdrs = 19'h10;
    bReq = 1'b1; bWe = 1'b0; bAdrs = 19'h10;
    for (int c = 0; c < 80 && q.size() < 10; c++) begin
      @(negedge clk);
      check("starve one grant", aGnt & bGnt, 1'b0);
      if (aGnt) q.push_back(1'b0);
      if (bGnt) q.push_back(1'b1);
    end
    idleInputs();
    check("starve grant total", q.size(), 10);
    for (int j = 0; j < 10 && j < q.size(); j++)
      check($sformatf("starve seq %0d", j), q[j], expSeq[j]);
    repeat (6) @(negedge clk);
  endtask

  task automatic writeRun();
    int k = 0;
    int gAt [3] = '{0, 0, 0};
    logic [AW-1:0] gAd [3];
    @(negedge clk);
    bReq = 1'b1; bWe = 1'b1; bAdrs = '0; bWrData = 8'h11;
    for (int c = 1; c <= 40 && k < 3; c++) begin
      @(negedge clk);
      if (bGnt) begin
        gAt[k] = c;
        gAd[k] = memAdrs;
        k++;
        if (k == 3) idleInputs();
        else bAdrs = AW'(k);
      end
    end
    idleInputs();
    check("wrun grants", k, 3);
    for (int j = 0; j < 3; j++)
      check($sformatf("wrun adrs %0d", j), gAd[j], j);
    check("wrun gap 1", gAt[1] - gAt[0], 5);
    check("wrun gap 2", gAt[2] - gAt[1], 5);
    repeat (6) @(negedge clk);
  endtask

  task automatic resetMidWrite();
    logic found = 1'b0;
    @(negedge clk);
    bReq = 1'b1; bWe = 1'b1; bAdrs = 19'h20; bWrData = 8'h99;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bGnt) bReq = 1'b0;
      if (!memWE) found = 1'b1;
    end
    check("rst reached pulse", found, 1'b1);
    #2 rst = 1'b1;
    idleInputs();
    #1;
    check("rst strobes", {memCE, memOE, memWE}, 3'b111);
    check("rst busy", busy, 1'b0);
    check("rst adrs", memAdrs, 0);
    check("rst pulses", {aGnt, bGnt, aRdVd, bRdVd}, 4'b0000);
    @(negedge clk);
    check("rst held pulses", {aGnt, bGnt, aRdVd, bRdVd, busy}, 5'b0);
    check("rst rd data", {aRdData, bRdData}, 16'h0);
    rst = 1'b0;
    runVec(10, vecs[0]);
  endtask

  task automatic writeThenRead();
    int gap = 0;
    int aG = 0;
    logic wrSeen = 1'b0;
    logic oeSeen = 1'b0;
    logic vdSeen = 1'b0;
    logic [DW-1:0] rd = '0;
    @(negedge clk);
    bReq = 1'b1; bWe = 1'b1; bAdrs = 19'h21; bWrData = 8'h77;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bGnt) begin
        bReq = 1'b0; aReq = 1'b1; aAdrs = 19'h21;
      end
      if (aGnt) begin
        aReq = 1'b0; aG++;
      end
      if (!memWE) wrSeen = 1'b1;
      if (wrSeen && !oeSeen && memCE && memOE && memWE) gap++;
      if (!memOE) oeSeen = 1'b1;
      if (aRdVd) begin
        vdSeen = 1'b1; rd = aRdData;
      end
    end
    idleInputs();
    check("raw idle gap", gap, 1);
    check("raw a grant", aG, 1);
    check("raw rdvd", vdSeen, 1'b1);
    check("raw rd data", rd, 8'h77);
  endtask

  task automatic randPhase(input int n);
    int freeAt = 0;
    int starve = 0;
    int vdAt = -1;
    logic vdPort = 1'b0;
    logic [DW-1:0] vdData = '0;
    logic [DW-1:0] refMem [16];
    logic expAG, expBG, pickB;
    logic [AW-1:0] adr;
    for (int j = 0; j < 16; j++) refMem[j] = seedVal(j);
    idleInputs();
    repeat (8) @(negedge clk);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      expAG = 1'b0;
      expBG = 1'b0;
      if (i >= freeAt) begin
        if (!bReq) starve = 0;
        if (aReq || bReq) begin
          pickB = bReq && (!aReq || starve == STARVE_MAX);
          if (pickB) begin
            expBG = 1'b1;
            starve = 0;
          end else begin
            expAG = 1'b1;
            if (bReq && starve < STARVE_MAX) starve++;
          end
          adr = pickB ? bAdrs : aAdrs;
          if (pickB && bWe) begin
            refMem[adr[3:0]] = bWrData;
            freeAt = i + 5;
          end else begin
            vdAt = i + RD_WAIT;
            vdPort = pickB;
            vdData = refMem[adr[3:0]];
            freeAt = i + RD_WAIT + 1;
          end
        end
      end
      check("rand a gnt", aGnt, expAG);
      check("rand b gnt", bGnt, expBG);
      check("rand a rdvd", aRdVd, i == vdAt && !vdPort);
      check("rand b rdvd", bRdVd, i == vdAt && vdPort);
      check("rand busy", busy, i < freeAt - 1);
      if (i == vdAt) check("rand rd data", vdPort ? bRdData : aRdData, vdData);
      if (expAG) aReq = 1'($urandom_range(0, 1));
      else if (!aReq) aReq = ($urandom_range(0, 2) == 0);
      if (expAG || !aReq) aAdrs = 19'h100 + AW'($urandom_range(0, 15));
      if (expBG || !bReq) begin
        bReq = expBG ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
        bWe = 1'($urandom_range(0, 1));
        bAdrs = 19'h100 + AW'($urandom_range(0, 15));
        bWrData = 8'($urandom_range(0, 255));
      end
    end
    idleInputs();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 19'h00010, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, 19'h7FFFF, 8'h3C, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 19'h7FFFF, 8'h00, 8'h3C};
    vecs[3] = '{1'b1, 1'b1, 19'h00001, 8'hC3, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 19'h00001, 8'h00, 8'hC3};
    vecs[5] = '{1'b1, 1'b0, 19'h00010, 8'h00, 8'h5A};

    rst = 1'b1;
    idleInputs();
    aAdrs = '0;
    bAdrs = '0;
    bWrData = '0;
    #2;
    check("reset strobes", {memCE, memOE, memWE}, 3'b111);
    check("reset adrs", memAdrs, 0);
    check("reset pulses", {aGnt, bGnt, aRdVd, bRdVd, busy}, 5'b0);
    check("reset rd data", {aRdData, bRdData}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) runVec(v, vecs[v]);
    starveSeq();
    writeRun();
    resetMidWrite();
    writeThenRead();
    randPhase(400);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
